// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants and producer encodings for the common-data-bus arbiter
package cdb_arbiter_pkg;

    localparam int ROB_W_DEF = 5;
    localparam int RES_W     = 32;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    // Recording LSB as the last winner lets the ALU take the first tie after reset/flush.
    localparam cdb_src_e LAST_GRANT_RST = CDB_SRC_LSB;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-producer circular result queue with synchronous clear
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A full queue refuses a push even when it pops on the same edge.
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin merge of ALU and LSB results onto the common data bus
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alu_valid,
    input  logic [31:0]      alu_res,
    input  logic [ROB_W-1:0] alu_rob_id,
    output logic             alu_ready,
    input  logic             lsb_valid,
    input  logic [31:0]      lsb_res,
    input  logic [ROB_W-1:0] lsb_rob_id,
    output logic             lsb_ready,
    output logic             cdb_valid,
    output logic [31:0]      cdb_res,
    output logic [ROB_W-1:0] cdb_rob_id,
    output logic             cdb_src
);

    localparam int DW = RES_W + ROB_W;

    logic          clear;
    logic          active;
    logic          alu_empty, alu_full, lsb_empty, lsb_full;
    logic [DW-1:0] alu_head, lsb_head, grant_head;
    logic          grant;
    cdb_src_e      grant_src;
    cdb_src_e      last_grant;

    assign clear     = rst | flush;
    assign active    = rdy & ~clear;
    assign alu_ready = active & ~alu_full;
    assign lsb_ready = active & ~lsb_full;

    cdb_fifo #(.DEPTH(DEPTH), .W(DW)) u_alu_q (
        .clk   (clk),
        .clear (clear),
        .push  (alu_valid & alu_ready),
        .din   ({alu_res, alu_rob_id}),
        .pop   (grant && grant_src == CDB_SRC_ALU),
        .empty (alu_empty),
        .full  (alu_full),
        .head  (alu_head)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W(DW)) u_lsb_q (
        .clk   (clk),
        .clear (clear),
        .push  (lsb_valid & lsb_ready),
        .din   ({lsb_res, lsb_rob_id}),
        .pop   (grant && grant_src == CDB_SRC_LSB),
        .empty (lsb_empty),
        .full  (lsb_full),
        .head  (lsb_head)
    );

    // Arbitration looks at queue state before this edge's pushes land.
    always_comb begin
        grant_src = CDB_SRC_ALU;
        if (!alu_empty && !lsb_empty)
            grant_src = (last_grant == CDB_SRC_LSB) ? CDB_SRC_ALU : CDB_SRC_LSB;
        else if (!lsb_empty)
            grant_src = CDB_SRC_LSB;
    end

    assign grant      = active & (~alu_empty | ~lsb_empty);
    assign grant_head = (grant_src == CDB_SRC_LSB) ? lsb_head : alu_head;

    always_ff @(posedge clk) begin
        if (clear) begin
            cdb_valid  <= 1'b0;
            cdb_res    <= '0;
            cdb_rob_id <= '0;
            cdb_src    <= CDB_SRC_ALU;
            last_grant <= LAST_GRANT_RST;
        end else if (rdy) begin
            cdb_valid <= grant;
            if (grant) begin
                cdb_res    <= grant_head[DW-1 -: RES_W];
                cdb_rob_id <= grant_head[ROB_W-1:0];
                cdb_src    <= grant_src;
                last_grant <= grant_src;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic [31:0] alu_res = '0;
    logic [4:0]  alu_rob_id = '0;
    logic        alu_ready;
    logic        lsb_valid = 1'b0;
    logic [31:0] lsb_res = '0;
    logic [4:0]  lsb_rob_id = '0;
    logic        lsb_ready;
    logic        cdb_valid;
    logic [31:0] cdb_res;
    logic [4:0]  cdb_rob_id;
    logic        cdb_src;

    int checks = 0;
    int failures = 0;

    logic [36:0] exp_a[$];
    logic [36:0] exp_l[$];
    int          a_n, l_n;
    logic        a_acc, l_acc;

    cdb_arbiter #(.DEPTH(4), .ROB_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_res    (alu_res),
        .alu_rob_id (alu_rob_id),
        .alu_ready  (alu_ready),
        .lsb_valid  (lsb_valid),
        .lsb_res    (lsb_res),
        .lsb_rob_id (lsb_rob_id),
        .lsb_ready  (lsb_ready),
        .cdb_valid  (cdb_valid),
        .cdb_res    (cdb_res),
        .cdb_rob_id (cdb_rob_id),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [31:0] res, input logic [4:0] rob,
                             input logic src);
        check({tag, "_valid"}, cdb_valid, 1);
        check({tag, "_res"}, cdb_res, res);
        check({tag, "_rob"}, cdb_rob_id, rob);
        check({tag, "_src"}, cdb_src, src);
    endtask

    task automatic do_reset();
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        flush = 1'b0;
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic score();
        if (cdb_valid) begin
            if (cdb_src == 1'b0) begin
                check("bp_alu_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) check("bp_alu_data", {cdb_res, cdb_rob_id}, exp_a.pop_front());
            end else begin
                check("bp_lsb_expected", exp_l.size() != 0, 1);
                if (exp_l.size() != 0) check("bp_lsb_data", {cdb_res, cdb_rob_id}, exp_l.pop_front());
            end
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsb_ready", lsb_ready, 0);
        check("rst_cdb_valid", cdb_valid, 0);
        check("rst_cdb_res", cdb_res, 0);
        check("rst_cdb_rob", cdb_rob_id, 0);
        check("rst_cdb_src", cdb_src, 0);
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", alu_ready, 1);
        check("post_rst_lsb_ready", lsb_ready, 1);

        // Single ALU result: broadcast two edges after the push
        alu_valid = 1'b1; alu_res = 32'h1234; alu_rob_id = 5'd3;
        tick();
        alu_valid = 1'b0;
        check("single_e0_valid", cdb_valid, 0);
        tick();
        check_bus("single", 32'h1234, 5'd3, 1'b0);
        tick();
        check("single_after_valid", cdb_valid, 0);
        check("single_hold_res", cdb_res, 32'h1234);

        // Tie after reset: ALU first, then LSB
        do_reset();
        alu_valid = 1'b1; alu_res = 32'h11; alu_rob_id = 5'd1;
        lsb_valid = 1'b1; lsb_res = 32'h22; lsb_rob_id = 5'd2;
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        check("tie_e0_valid", cdb_valid, 0);
        tick();
        check_bus("tie1_first", 32'h11, 5'd1, 1'b0);
        tick();
        check_bus("tie1_second", 32'h22, 5'd2, 1'b1);
        tick();
        check("tie1_idle", cdb_valid, 0);
        // Lone ALU grant makes ALU the last winner, so the next tie goes to LSB
        alu_valid = 1'b1; alu_res = 32'h99; alu_rob_id = 5'd9;
        tick();
        alu_valid = 1'b0;
        tick();
        check_bus("lone_alu", 32'h99, 5'd9, 1'b0);
        alu_valid = 1'b1; alu_res = 32'h55; alu_rob_id = 5'd5;
        lsb_valid = 1'b1; lsb_res = 32'h66; lsb_rob_id = 5'd6;
        tick();
        alu_valid = 1'b0; lsb_valid = 1'b0;
        check("tie2_e0_valid", cdb_valid, 0);
        tick();
        check_bus("tie2_first", 32'h66, 5'd6, 1'b1);
        tick();
        check_bus("tie2_second", 32'h55, 5'd5, 1'b0);

        // Backpressure: both producers stream continuously
        do_reset();
        a_n = 0; l_n = 0;
        alu_valid = 1'b1; lsb_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            alu_res = 32'hA000_0000 + a_n; alu_rob_id = 5'(a_n);
            lsb_res = 32'hB000_0000 + l_n; lsb_rob_id = 5'(l_n + 16);
            #1;
            a_acc = alu_ready; l_acc = lsb_ready;
            if (a_acc) exp_a.push_back({alu_res, alu_rob_id});
            if (l_acc) exp_l.push_back({lsb_res, lsb_rob_id});
            tick();
            if (a_acc) a_n++;
            if (l_acc) l_n++;
            score();
            if (c == 5) begin
                check("bp_alu_ready_e5", alu_ready, 1);
                check("bp_lsb_ready_e5", lsb_ready, 0);
            end
            if (c == 6) check("bp_alu_ready_e6", alu_ready, 0);
        end
        alu_valid = 1'b0; lsb_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            score();
        end
        check("bp_alu_drained", exp_a.size(), 0);
        check("bp_lsb_drained", exp_l.size(), 0);
        check("bp_idle", cdb_valid, 0);

        // Flush mid-stream: queued tags never reach the bus
        do_reset();
        alu_valid = 1'b1; alu_res = 32'h10; alu_rob_id = 5'd10;
        lsb_valid = 1'b1; lsb_res = 32'h20; lsb_rob_id = 5'd20;
        tick();
        alu_res = 32'h11; alu_rob_id = 5'd11;
        lsb_res = 32'h21; lsb_rob_id = 5'd21;
        tick();
        check_bus("fl_pre_a", 32'h10, 5'd10, 1'b0);
        lsb_valid = 1'b0;
        alu_res = 32'h12; alu_rob_id = 5'd12;
        tick();
        check_bus("fl_pre_l", 32'h20, 5'd20, 1'b1);
        flush = 1'b1;
        alu_res = 32'h13; alu_rob_id = 5'd13;
        tick();
        flush = 1'b0; alu_valid = 1'b0;
        #1;
        check("fl_valid", cdb_valid, 0);
        check("fl_rob", cdb_rob_id, 0);
        check("fl_alu_ready", alu_ready, 1);
        check("fl_lsb_ready", lsb_ready, 1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("fl_quiet", cdb_valid, 0);
        end

        // rdy low: state and outputs freeze, inputs ignored
        do_reset();
        alu_valid = 1'b1; alu_res = 32'h30; alu_rob_id = 5'd30;
        lsb_valid = 1'b1; lsb_res = 32'h40; lsb_rob_id = 5'd8;
        tick();
        lsb_valid = 1'b0;
        alu_res = 32'h31; alu_rob_id = 5'd31;
        tick();
        check_bus("rdy_pre", 32'h30, 5'd30, 1'b0);
        rdy = 1'b0;
        alu_res = 32'h63; alu_rob_id = 5'd7;
        #1;
        check("rdy_alu_ready", alu_ready, 0);
        check("rdy_lsb_ready", lsb_ready, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bus("rdy_hold", 32'h30, 5'd30, 1'b0);
        end
        rdy = 1'b1; alu_valid = 1'b0;
        tick();
        check_bus("rdy_resume1", 32'h40, 5'd8, 1'b1);
        tick();
        check_bus("rdy_resume2", 32'h31, 5'd31, 1'b0);
        tick();
        check("rdy_resume_idle", cdb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
